// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: runs one FIR output per accepted sample through a shared 16x16 MAC.
// Define FIR_SAT_EN to clamp the scaled accumulator to the signed 16-bit range.
module fir_mac_sequencer #(
    parameter int NTAPS   = 4,
    parameter int MAC_LAT = 2,
    parameter int SHIFT   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [24:0] sample_in,
    output logic        ready,
    output logic [7:0]  coef_addr,
    input  logic [15:0] coef_data,
    output logic [15:0] mac_a,
    output logic [15:0] mac_b,
    output logic        mac_ce,
    output logic        mac_load,
    input  logic [31:0] mac_o,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        overrun
);
    localparam int TW = $clog2(NTAPS);
    localparam int DW = $clog2(MAC_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, CAPTURE} state_t;

    state_t                  state;
    logic [NTAPS-1:0][15:0]  win;
    logic [TW-1:0]           tap;
    logic [DW-1:0]           cnt;
    logic [15:0]             scaled;
    logic                    unused_bits;

    assign ready       = state == IDLE;
    // coefficient store reads combinationally, so the coefficient operand follows it in the same cycle
    assign mac_a       = mac_ce ? coef_data : '0;
    assign unused_bits = ^{sample_in[24], sample_in[7:0], mac_o};

`ifdef FIR_SAT_EN
    logic signed [31:0] shr;
    assign shr    = $signed(mac_o) >>> SHIFT;
    assign scaled = shr > 32'sd32767 ? 16'h7fff : shr < -32'sd32768 ? 16'h8000 : shr[15:0];
`else
    assign scaled = mac_o[SHIFT+15:SHIFT];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            win          <= '0;
            tap          <= '0;
            cnt          <= '0;
            coef_addr    <= '0;
            mac_b        <= '0;
            mac_ce       <= 1'b0;
            mac_load     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (sample_valid && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (sample_valid) begin
                    // new oldest sample lands in win[0] after the shift, i.e. old win[1]
                    win       <= {sample_in[23:8], win[NTAPS-1:1]};
                    state     <= RUN;
                    tap       <= '0;
                    coef_addr <= '0;
                    mac_b     <= win[1];
                    mac_ce    <= 1'b1;
                    mac_load  <= 1'b1;
                end
                RUN: if (tap == TW'(NTAPS - 1)) begin
                    state     <= DRAIN;
                    tap       <= '0;
                    cnt       <= '0;
                    coef_addr <= '0;
                    mac_b     <= '0;
                    mac_ce    <= 1'b0;
                    mac_load  <= 1'b0;
                end else begin
                    tap       <= tap + TW'(1);
                    coef_addr <= coef_addr + 8'd1;
                    mac_b     <= win[tap + TW'(1)];
                    mac_load  <= 1'b0;
                end
                DRAIN: if (cnt == DW'(MAC_LAT - 1))
                    state <= CAPTURE;
                else
                    cnt <= cnt + DW'(1);
                CAPTURE: begin
                    result       <= scaled;
                    result_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: random and directed stimulus against a cycle-indexed FIR reference model.
module tb_fir_mac_sequencer;
    localparam int NTAPS   = 4;
    localparam int MAC_LAT = 2;
    localparam int SHIFT   = 0;
    localparam int LAT     = NTAPS + MAC_LAT + 1;

    logic        clk, reset, sample_valid;
    logic [24:0] sample_in;
    logic        ready, mac_ce, mac_load, result_valid, overrun;
    logic [7:0]  coef_addr;
    logic [15:0] coef_data, mac_a, mac_b, result;
    logic [31:0] mac_o = '0;
    logic [31:0] acc = '0;
    logic signed [32:0] prod;
    logic [15:0] coef [256];

    fir_mac_sequencer #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .ready(ready), .coef_addr(coef_addr), .coef_data(coef_data), .mac_a(mac_a),
        .mac_b(mac_b), .mac_ce(mac_ce), .mac_load(mac_load), .mac_o(mac_o),
        .result(result), .result_valid(result_valid), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // coefficient store and a behavioural MAC whose output trails the accumulator by one cycle
    assign coef_data = coef[coef_addr];
    assign prod = $signed(mac_a) * $signed({1'b0, mac_b});
    always @(posedge clk) begin
        if (mac_ce) acc <= mac_load ? prod[31:0] : acc + prod[31:0];
        mac_o <= acc;
    end

    int total = 0, bad = 0, cyc = 0, acc_edge = -100;
    bit started = 0, movr = 0, exp_rv = 0;
    logic [15:0] exp_res = '0;
    logic [15:0] mwin [NTAPS];
    logic [15:0] snap [NTAPS];
    int due_q [$];
    logic [15:0] val_q [$];
    logic [15:0] rv_log [$];
    int rv_cyc [$];
    int acc_e [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] scale(input logic [31:0] m);
        longint sh = longint'($signed(m)) >>> SHIFT;
`ifdef FIR_SAT_EN
        if (sh > 32767) return 16'h7fff;
        if (sh < -32768) return 16'h8000;
`endif
        return sh[15:0];
    endfunction

    function automatic logic [15:0] fir_value();
        longint s = 0;
        for (int k = 0; k < NTAPS; k++)
            s += longint'($signed(coef[k])) * longint'({1'b0, mwin[k]});
        return scale(s[31:0]);
    endfunction

    // reference: accepts when the previous cycle was free, result due LAT edges after the accept edge
    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) mwin[k] = '0;
            acc_edge = -100; movr = 0; exp_res = '0; exp_rv = 0;
            due_q.delete(); val_q.delete();
            started = 1;
        end else begin
            exp_rv = 0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                exp_rv = 1; exp_res = val_q[0];
                void'(due_q.pop_front()); void'(val_q.pop_front());
            end
            if (sample_valid) begin
                if (cyc - 1 >= acc_edge + LAT) begin
                    for (int k = 0; k < NTAPS - 1; k++) mwin[k] = mwin[k+1];
                    mwin[NTAPS-1] = sample_in[23:8];
                    snap = mwin;
                    acc_edge = cyc;
                    due_q.push_back(cyc + LAT);
                    val_q.push_back(fir_value());
                end else movr = 1;
            end
        end
    end

    always @(negedge clk) if (started) begin
        int k;
        k = cyc - acc_edge;
        chk("ready", ready, cyc >= acc_edge + LAT);
        chk("result_valid", result_valid, exp_rv);
        chk("result", result, exp_res);
        chk("overrun", overrun, movr);
        if (k >= 0 && k < NTAPS) begin
            chk("mac_ce_run", mac_ce, 1);
            chk("coef_addr_run", coef_addr, k);
            chk("mac_load_run", mac_load, k == 0);
            chk("mac_b_run", mac_b, snap[k]);
            chk("mac_a_run", mac_a, coef[k]);
        end else begin
            chk("mac_ce_off", mac_ce, 0);
            chk("mac_load_off", mac_load, 0);
            if (cyc >= acc_edge + LAT) begin
                chk("coef_addr_idle", coef_addr, 0);
                chk("mac_a_idle", mac_a, 0);
                chk("mac_b_idle", mac_b, 0);
            end
        end
        if (result_valid) begin
            rv_log.push_back(result);
            rv_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [15:0] v);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in = {1'($urandom), v, 8'($urandom)};
        acc_e.push_back(cyc + 1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        pulse(v);
        idle(6);
    endtask

    task automatic set_taps(input logic [15:0] c0, c1, c2, c3);
        coef[0] = c0; coef[1] = c1; coef[2] = c2; coef[3] = c3;
    endtask

    initial begin
        int e1 [4] = '{40, 110, 200, 300};
        reset = 1'b0; sample_valid = 1'b0; sample_in = '0;
        for (int i = 0; i < 256; i++) coef[i] = 16'($urandom);
        set_taps(1, 2, 3, 4);
        idle(3);
        reset = 1'b1;
        chk("rst_result", result, 0);
        chk("rst_ready", ready, 1);
        chk("rst_overrun", overrun, 0);
        chk("rst_mac_ce", mac_ce, 0);

        rv_log.delete(); rv_cyc.delete(); acc_e.delete();
        send(10); send(20); send(30); send(40);
        idle(3);
        chk("p1_count", rv_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("p1_value", i < rv_log.size() ? rv_log[i] : 16'hxxxx, e1[i]);
            chk("p1_latency", i < rv_cyc.size() ? rv_cyc[i] - acc_e[i] : -1, LAT);
        end

        pulse(16'h0123);
        @(negedge clk);
        sample_valid = 1'b1; sample_in = {1'b0, 16'h0456, 8'h00};
        @(negedge clk);
        sample_valid = 1'b0;
        idle(8);
        chk("ovr_set", overrun, 1);
        idle(4);
        chk("ovr_sticky", overrun, 1);

        set_taps(16'h7fff, 0, 0, 0);
        rv_log.delete();
        send(16'hffff); send(0); send(0); send(0);
        idle(3);
`ifdef FIR_SAT_EN
        chk("sat_value", rv_log.size() == 4 ? rv_log[3] : 16'hxxxx, 16'h7fff);
`else
        chk("sat_value", rv_log.size() == 4 ? rv_log[3] : 16'hxxxx, 16'h8001);
`endif

        set_taps(1, 2, 3, 4);
        idle(2);
        pulse(16'd7);
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_ce", mac_ce, 0);
        chk("rst_mid_ovr", overrun, 0);
        idle(2);
        rv_log.delete();
        send(16'd5);
        idle(3);
        chk("rst_mid_count", rv_log.size(), 1);
        chk("rst_mid_value", rv_log.size() > 0 ? rv_log[0] : 16'hxxxx, 20);

        rv_log.delete();
        repeat (40) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_in = 25'($urandom);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        idle(10);
        chk("cont_results", rv_log.size(), 5);
        chk("cont_overrun", overrun, 1);

        for (int i = 0; i < NTAPS; i++) coef[i] = 16'($urandom);
        repeat (1500) begin
            @(negedge clk);
            sample_valid = $urandom_range(0, 4) == 0;
            sample_in = 25'($urandom);
            reset = $urandom_range(0, 299) != 0;
        end
        sample_valid = 1'b0;
        reset = 1'b1;
        idle(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
